// File: rtl/sync_down_load.sv
// sync_down_load: loadable down counter with terminal-count pulse.
// With AUTO_RELOAD=1 the counter reloads after reaching zero and runs as a divider or timer.
// With AUTO_RELOAD=0 it is a one-shot that stops at zero until the next load.
module sync_down_load #(
  parameter int WIDTH       = 2,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,       // active-low, asynchronous
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic {RUN, HALT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] rld, rld_nx;
  logic             tc_nx, done_nx;

  assign zero = (q == ZERO);

  // State and datapath registers; reset parks the count at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      q     <= '1;
      rld   <= '1;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      rld   <= rld_nx;
      tc    <= tc_nx;
      done  <= done_nx;
    end
  end

  // Next state: load beats everything, then the decrement / reload / halt rules
  always_comb begin
    state_nx = state;
    q_nx     = q;
    rld_nx   = rld;
    tc_nx    = 1'b0;
    done_nx  = done;
    if (load) begin
      q_nx     = load_val;
      rld_nx   = load_val;
      done_nx  = 1'b0;
      state_nx = RUN;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (q > ONE) begin
              q_nx = q - ONE;
            end else if (q == ONE) begin
              // tc only fires on the 1 -> 0 step, never on a load of 0
              q_nx  = ZERO;
              tc_nx = 1'b1;
              if (!AUTO_RELOAD) begin
                state_nx = HALT;
                done_nx  = 1'b1;
              end
            end else begin
              // Already at zero: reload instead of wrapping to all-ones
              if (AUTO_RELOAD) begin
                q_nx = rld;
              end else begin
                state_nx = HALT;
                done_nx  = 1'b1;
              end
            end
          end
        end
        HALT: begin
          // One-shot parked at zero; only a load restarts it
          q_nx = ZERO;
        end
        default: state_nx = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_down_load.sv
// Bench for sync_down_load: one auto-reload and one one-shot instance share the stimulus.
// Each instance is checked against fixed vectors and a behavioural model.
module tb_sync_down_load;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q_ar, q_os;
  logic         zero_ar, zero_os, tc_ar, tc_os, done_ar, done_os;

  int checks = 0;
  int failures = 0;

  sync_down_load #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_ar (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .q(q_ar), .zero(zero_ar), .tc(tc_ar), .done(done_ar));

  sync_down_load #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_os (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .q(q_os), .zero(zero_os), .tc(tc_os), .done(done_os));

  always #5 clk = ~clk;

  // Behavioural model: index 1 = auto-reload, index 0 = one-shot
  int  m_q[2], m_r[2];
  bit  m_tc[2], m_done[2], m_halt[2];

  function automatic void model_reset();
    for (int a = 0; a < 2; a++) begin
      m_q[a] = (1 << W) - 1; m_r[a] = (1 << W) - 1;
      m_tc[a] = 0; m_done[a] = 0; m_halt[a] = 0;
    end
  endfunction

  function automatic void model_edge(bit e, bit l, int lv);
    for (int a = 0; a < 2; a++) begin
      m_tc[a] = 0;
      if (l) begin
        m_q[a] = lv; m_r[a] = lv; m_done[a] = 0; m_halt[a] = 0;
      end else if (!m_halt[a] && e) begin
        if (m_q[a] == 0) begin
          if (a == 1) m_q[a] = m_r[a];
          else begin m_halt[a] = 1; m_done[a] = 1; end
        end else begin
          m_q[a] = m_q[a] - 1;
          if (m_q[a] == 0) begin
            m_tc[a] = 1;
            if (a == 0) begin m_halt[a] = 1; m_done[a] = 1; end
          end
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " ar q"},    q_ar,    m_q[1]);
    chk({tag, " ar tc"},   tc_ar,   m_tc[1]);
    chk({tag, " ar zero"}, zero_ar, m_q[1] == 0);
    chk({tag, " ar done"}, done_ar, 0);
    chk({tag, " os q"},    q_os,    m_q[0]);
    chk({tag, " os tc"},   tc_os,   m_tc[0]);
    chk({tag, " os zero"}, zero_os, m_q[0] == 0);
    chk({tag, " os done"}, done_os, m_done[0]);
  endtask

  // Inputs are set at a negedge; the step applies one posedge and samples at the next negedge
  task automatic step();
    @(posedge clk);
    model_edge(en, load, int'(load_val));
    @(negedge clk);
  endtask

  typedef struct {
    bit en; bit load; int lv; int exp_q; bit exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(bit e, bit l, int lv, int eq, bit et);
    vec_t v;
    v.en = e; v.load = l; v.lv = lv; v.exp_q = eq; v.exp_tc = et;
    vecs.push_back(v);
  endfunction

  initial begin
    // Auto-reload vectors: free run from reset, load-wins, enable gating, load of 0
    addv(1,0,0, 2,0); addv(1,0,0, 1,0); addv(1,0,0, 0,1); addv(1,0,0, 3,0);
    addv(1,0,0, 2,0);
    addv(1,1,2, 2,0);
    addv(1,0,0, 1,0); addv(1,0,0, 0,1); addv(1,0,0, 2,0); addv(1,0,0, 1,0);
    addv(1,0,0, 0,1); addv(1,0,0, 2,0);
    addv(0,0,0, 2,0); addv(0,0,0, 2,0); addv(0,0,0, 2,0);
    addv(1,0,0, 1,0); addv(1,0,0, 0,1);
    addv(1,1,0, 0,0); addv(1,0,0, 0,0); addv(1,0,0, 0,0); addv(1,0,0, 0,0);

    model_reset();
    // Reset state, held without any clock dependence
    #12;
    chk("reset ar q", q_ar, 3);       chk("reset ar zero", zero_ar, 0);
    chk("reset ar tc", tc_ar, 0);     chk("reset ar done", done_ar, 0);
    chk("reset os q", q_os, 3);       chk("reset os done", done_os, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en; load = vecs[i].load; load_val = W'(vecs[i].lv);
      step();
      chk($sformatf("vec%0d q", i), q_ar, vecs[i].exp_q);
      chk($sformatf("vec%0d tc", i), tc_ar, vecs[i].exp_tc);
      chk($sformatf("vec%0d zero", i), zero_ar, vecs[i].exp_q == 0);
      chk_model($sformatf("vec%0d", i));
    end

    // One-shot: load 1, count to zero, stay halted, then reload 3
    en = 1; load = 1; load_val = 2'd1; step();
    chk("os load1 q", q_os, 1); chk("os load1 done", done_os, 0);
    load = 0; step();
    chk("os hit q", q_os, 0); chk("os hit tc", tc_os, 1); chk("os hit done", done_os, 1);
    step();
    chk("os halt q", q_os, 0); chk("os halt tc", tc_os, 0); chk("os halt done", done_os, 1);
    step();
    chk("os halt2 q", q_os, 0); chk("os halt2 tc", tc_os, 0);
    load = 1; load_val = 2'd3; step();
    chk("os reload q", q_os, 3); chk("os reload done", done_os, 0);
    load = 0; step(); chk("os c2", q_os, 2);
    step(); chk("os c1", q_os, 1); chk("os c1 tc", tc_os, 0);
    step(); chk("os c0", q_os, 0); chk("os c0 tc", tc_os, 1); chk("os c0 done", done_os, 1);
    chk_model("os seq");

    // Asynchronous reset between edges while q=1
    load = 1; load_val = 2'd2; step();
    load = 0; step();
    chk("pre-rst ar q", q_ar, 1); chk("pre-rst os q", q_os, 1);
    #2 rst = 0;
    #1;
    chk("async ar q", q_ar, 3); chk("async ar tc", tc_ar, 0);
    chk("async os q", q_os, 3); chk("async os done", done_os, 0);
    model_reset();
    #1 rst = 1;
    step();
    chk("post-rst ar q", q_ar, 2); chk("post-rst os q", q_os, 2);
    chk_model("post-rst");

    // Random traffic against the model, with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 0;
        #1 model_reset();
        chk_model("rnd rst");
        #1 rst = 1;
      end
      step();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
